store_unit: RTL and testbench

- Register-to-memory store path of the CPU; the write direction opposite to the load/write-back select.
- Takes a store request from the MEM stage: address, LSB-justified register data and size.
- Aligns the data into byte lanes, generates byte enables and runs a req/ack handshake with data memory.
- Stalls the pipeline while a store is outstanding.

---
 rtl/store_unit.sv | 132 +++++++++++++
 tb/tb_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store path: aligns register data into byte lanes and writes it to data memory over req/ack.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned half/word stores with st_err.
module store_unit #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, nstate;
  logic [CW-1:0] cnt;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic        mis, bad, acc, ld, tmo;
  logic        done_n, err_n;

  always_comb begin
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (st_size)
      2'b00: begin
        be_n = 4'b0001 << st_addr[1:0];
        wd_n = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_n = st_addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{st_data[15:0]}};
      end
      2'b10: begin
        be_n = 4'b1111;
        wd_n = st_data;
      end
      default: begin
        be_n = 4'b0000;
        wd_n = 32'h0;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign mis = ((st_size == 2'b01) & st_addr[0])
             | ((st_size == 2'b10) & (st_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign bad = (st_size == 2'b11) | mis;
  assign tmo = (WAIT_MAX > 0) && (state == BUSY)
             && !mem_ack && (cnt == LAST);

  // A rejected request arriving with an ack waits one cycle so that
  // its st_err never lands on the same cycle as the st_done.
  always_comb begin
    st_ready = 1'b1;
    mem_req  = 1'b0;
    if (state == BUSY) begin
      st_ready = mem_ack & ~(st_valid & bad);
      mem_req  = 1'b1;
    end
    stall = st_valid & ~st_ready;
    acc   = st_valid & st_ready;
  end

  always_comb begin
    nstate = state;
    ld     = 1'b0;
    done_n = 1'b0;
    err_n  = 1'b0;
    if (state == BUSY) begin
      if (mem_ack) begin
        done_n = 1'b1;
        nstate = IDLE;
      end else if (tmo) begin
        err_n  = 1'b1;
        nstate = IDLE;
      end
    end
    if (acc) begin
      if (bad) begin
        err_n = 1'b1;
      end else begin
        ld     = 1'b1;
        nstate = BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      state   <= nstate;
      st_done <= done_n;
      st_err  <= err_n;
      if (ld) begin
        cnt       <= '0;
        mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= wd_n;
        mem_be    <= be_n;
      end else if (state == BUSY && !mem_ack) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit with a latency-programmable memory responder.
// Built with WAIT_MAX=4 so the timeout path is reachable quickly.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [1:0]  st_size = 2'b00;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        st_done;
  logic        st_err;

  store_unit #(.ADDR_W(32), .WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;
  int req_cnt = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lat = 0;

  logic [67:0] wq[$];
  bit          rq[$];

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Memory model: ack on cycle index 'lat' of each request, never if lat<0.
  int w = 0;
  logic rq_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!mem_req || !rq_prev || mem_ack) w = 0;
    else w = w + 1;
    rq_prev = mem_req;
    mem_ack = mem_req && lat >= 0 && w == lat;
  end

  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [67:0] p_wr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (mem_req) req_cnt++;
      if (stall) stall_cnt++;
      if (mem_req && p_req && !p_ack)
        chk("hold", {mem_addr, mem_wdata, mem_be}, p_wr);
      if (mem_req && mem_ack) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("write", {mem_addr, mem_wdata, mem_be}, wq.pop_front());
      end
      if (st_done || st_err) begin
        chk("done_err_excl", st_done & st_err, 0);
        if (rq.size() == 0) chk("unexpected_rsp", {st_done, st_err}, 0);
        else chk("rsp_kind", st_done, rq.pop_front());
        if (st_done) begin
          done_cnt++;
          chk("done_after_ack", p_req & p_ack, 1);
        end
        if (st_err) err_cnt++;
      end
      p_req = mem_req;
      p_ack = mem_ack;
      p_wr  = {mem_addr, mem_wdata, mem_be};
    end
  end

  task automatic send(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (st_ready) begin
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 1, 0);
    st_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40; i++) begin
      if (rq.size() == 0) break;
      @(posedge clk);
    end
    chk("rsp_drain", rq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string n);
    chk(n, {mem_req, mem_addr, mem_wdata, mem_be, st_done, st_err}, 0);
  endtask

  int r0, d0, e0, s0;

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    chk("reset_ready", {st_ready, stall}, 2'b10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat = 2;
    r0 = req_cnt;
    wq.push_back({32'h1000, 32'hABABABAB, 4'b1000});
    rq.push_back(1);
    send(2'b00, 32'h1003, 32'h000000AB);
    wait_rsp();
    chk("byte_req_cycles", req_cnt - r0, 3);

    lat = 0;
    r0 = req_cnt; d0 = done_cnt; s0 = stall_cnt;
    wq.push_back({32'h0, 32'h11111111, 4'b1111});
    wq.push_back({32'h4, 32'h22222222, 4'b1111});
    wq.push_back({32'h8, 32'h33333333, 4'b1111});
    repeat (3) rq.push_back(1);
    send(2'b10, 32'h0, 32'h11111111);
    send(2'b10, 32'h4, 32'h22222222);
    send(2'b10, 32'h8, 32'h33333333);
    wait_rsp();
    chk("b2b_req_cycles", req_cnt - r0, 3);
    chk("b2b_done", done_cnt - d0, 3);
    chk("b2b_stall", stall_cnt - s0, 0);

    lat = 1;
    wq.push_back({32'h20, 32'hBEEFBEEF, 4'b1100});
    rq.push_back(1);
    send(2'b01, 32'h22, 32'h1234BEEF);
    wait_rsp();
    r0 = req_cnt;
    rq.push_back(0);
    send(2'b11, 32'h40, 32'hDEADBEEF);
    wait_rsp();
    chk("reserved_no_req", req_cnt - r0, 0);

    lat = -1;
    r0 = req_cnt; s0 = stall_cnt; d0 = done_cnt;
    rq.push_back(0);
    rq.push_back(0);
    send(2'b10, 32'h200, 32'hCAFEF00D);
    send(2'b11, 32'h204, 32'h0);
    wait_rsp();
    chk("tmo_req_cycles", req_cnt - r0, 4);
    chk("tmo_stall_cycles", stall_cnt - s0, 4);
    chk("tmo_no_done", done_cnt - d0, 0);

    lat = 3;
    r0 = req_cnt; e0 = err_cnt;
    wq.push_back({32'h300, 32'h5A5A5A5A, 4'b1111});
    rq.push_back(1);
    send(2'b10, 32'h300, 32'h5A5A5A5A);
    wait_rsp();
    chk("late_ack_req_cycles", req_cnt - r0, 4);
    chk("late_ack_no_err", err_cnt - e0, 0);

    lat = 1;
    r0 = req_cnt;
`ifdef STORE_MISALIGN_TRAP_EN
    rq.push_back(0);
    send(2'b10, 32'h102, 32'h87654321);
    wait_rsp();
    chk("misalign_no_req", req_cnt - r0, 0);
`else
    wq.push_back({32'h100, 32'h87654321, 4'b1111});
    rq.push_back(1);
    send(2'b10, 32'h102, 32'h87654321);
    wait_rsp();
    chk("misalign_req_cycles", req_cnt - r0, 2);
`endif

    lat = -1;
    send(2'b10, 32'h400, 32'h0BADF00D);
    @(posedge clk);
    chk("busy_before_reset", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    @(negedge clk);
    chk_zero("reset_hold_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    wq.push_back({32'h4, 32'h77777777, 4'b0010});
    rq.push_back(1);
    send(2'b00, 32'h5, 32'h00000077);
    wait_rsp();
    chk("write_queue_empty", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
